// File: rtl/alu_issue_arbiter.sv
// Round-robin issue arbiter sharing one combinational ALU between two requesters.
// Latches the granted operation, runs one EXEC cycle, holds a tagged response until consumed.
module alu_issue_arbiter #(
  parameter int unsigned WORD_SIZE = 19,
  parameter int unsigned OP_W      = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [OP_W-1:0]      req0_op,
  input  logic                 req0_mode,
  input  logic [WORD_SIZE-1:0] req0_a,
  input  logic [WORD_SIZE-1:0] req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [OP_W-1:0]      req1_op,
  input  logic                 req1_mode,
  input  logic [WORD_SIZE-1:0] req1_a,
  input  logic [WORD_SIZE-1:0] req1_b,
  output logic [OP_W-1:0]      alu_op,
  output logic                 alu_mode,
  output logic [WORD_SIZE-1:0] alu_a,
  output logic [WORD_SIZE-1:0] alu_b,
  input  logic [WORD_SIZE-1:0] alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                 state_q;
  logic [OP_W-1:0]        alu_op_q;
  logic                   alu_mode_q;
  logic [WORD_SIZE-1:0]   alu_a_q;
  logic [WORD_SIZE-1:0]   alu_b_q;
  logic                   last_grant_q;
  logic                   cur_id_q;
  logic                   rsp_valid_q;
  logic                   rsp_id_q;
  logic [WORD_SIZE-1:0]   rsp_data_q;

  logic                   grant;
  logic                   can_accept;
  logic                   accept;
  logic [OP_W-1:0]        op_d;
  logic                   mode_d;
  logic [WORD_SIZE-1:0]   a_d;
  logic [WORD_SIZE-1:0]   b_d;

  always_comb begin
    grant      = 1'b0;
    can_accept = 1'b0;
    accept     = 1'b0;
    // Under contention the requester that did not win last time takes the grant.
    if (req0_valid && req1_valid) grant = ~last_grant_q;
    else                          grant = req1_valid;
    can_accept = reset && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
    accept     = can_accept && (req0_valid || req1_valid);
    req0_ready = can_accept && req0_valid && (grant == 1'b0);
    req1_ready = can_accept && req1_valid && (grant == 1'b1);
    op_d       = grant ? req1_op   : req0_op;
    mode_d     = grant ? req1_mode : req0_mode;
    a_d        = grant ? req1_a    : req0_a;
    b_d        = grant ? req1_b    : req0_b;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      alu_op_q     <= '0;
      alu_mode_q   <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      last_grant_q <= 1'b1;
      cur_id_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) state_q <= EXEC;
        EXEC: begin
          rsp_data_q  <= alu_result;
          rsp_id_q    <= cur_id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= accept ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        alu_op_q     <= op_d;
        alu_mode_q   <= mode_d;
        alu_a_q      <= a_d;
        alu_b_q      <= b_d;
        last_grant_q <= grant;
        cur_id_q     <= grant;
      end
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_mode  = alu_mode_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = reset && (state_q != IDLE);

endmodule
